// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the data-memory bus arbiter.
//   arb_state_t : who owns the memory port (nobody, CPU or DMA/IO)
//   side_t      : identifies a requester, used for the round-robin memory
//   AW_DEF/DW_DEF : default address and data widths
package mem_bus_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_CPU = 1'b0,
    SIDE_DMA = 1'b1
  } side_t;

endpackage

// File: rtl/mem_bus_arbiter_mem_port_mux.sv
// Combinational owner-select of the memory command.
//   cpu_sel / dma_sel        : a transfer for that requester happens this cycle
//                              (at most one is high)
//   cpu_* / dma_* (we, addr, wdata) : requester command inputs
//   mem_en, mem_we, mem_addr, mem_wdata : command to the memory; all zero
//                              when no transfer happens
module mem_port_mux
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          dma_sel,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  // Idle bus is driven to zero so the memory never sees a stale address.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_sel) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_sel) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port data memory between the CPU control path and a
// DMA/IO requester. Registered grant FSM with round-robin or CPU-priority
// tie-break, bounded tenure while the other side waits, and a one-cycle
// read-valid strobe routed back to whichever requester issued the read.
//   clk, rst_n                 : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      : CPU command, held until transferred
//   cpu_gnt, cpu_rvalid, cpu_rdata : CPU grant, read strobe, read data
//   dma_*                      : same roles for the DMA/IO requester
//   mem_en/we/addr/wdata       : memory command (zero when no transfer)
//   mem_rdata                  : memory read data, valid one cycle after a read
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int MAX_HOLD     = 4,
  parameter int CPU_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    state, state_nxt;
  logic [HW-1:0] hold_cnt;
  side_t         rr_last;
  logic          cpu_rd_tag, dma_rd_tag;
  logic          cpu_xfer, dma_xfer;
  logic          hold_done;

  // Grants come straight from the state register, so no req->gnt path exists.
  assign cpu_gnt  = (state == ARB_CPU);
  assign dma_gnt  = (state == ARB_DMA);
  assign cpu_xfer = cpu_gnt & cpu_req;
  assign dma_xfer = dma_gnt & dma_req;

  // The current transfer is the last one of this tenure if the other side waits.
  assign hold_done = (hold_cnt == HOLD_LAST);

  assign cpu_rvalid = cpu_rd_tag;
  assign dma_rvalid = dma_rd_tag;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

  mem_port_mux #(.AW(AW), .DW(DW)) u_mux (
    .cpu_sel   (cpu_xfer),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dma_sel   (dma_xfer),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Next owner: a dropped request hands over directly to a waiting side, and
  // a held request yields only once its tenure budget is spent.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (cpu_req && dma_req) begin
          if (CPU_PRIORITY != 0 || rr_last == SIDE_DMA) state_nxt = ARB_CPU;
          else                                          state_nxt = ARB_DMA;
        end else if (cpu_req) begin
          state_nxt = ARB_CPU;
        end else if (dma_req) begin
          state_nxt = ARB_DMA;
        end
      end
      ARB_CPU: begin
        if (!cpu_req)                    state_nxt = dma_req ? ARB_DMA : ARB_IDLE;
        else if (dma_req && hold_done)   state_nxt = ARB_DMA;
      end
      ARB_DMA: begin
        if (!dma_req)                    state_nxt = cpu_req ? ARB_CPU : ARB_IDLE;
        else if (cpu_req && hold_done)   state_nxt = ARB_CPU;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Owner, tenure counter, round-robin memory and read-return tags. The tags
  // record which side issued a read so the strobe follows the issuer even if
  // ownership changes on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      hold_cnt   <= '0;
      rr_last    <= SIDE_DMA;
      cpu_rd_tag <= 1'b0;
      dma_rd_tag <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_rd_tag <= cpu_xfer & ~cpu_we;
      dma_rd_tag <= dma_xfer & ~dma_we;
      if (state_nxt != state)
        hold_cnt <= '0;
      else if ((cpu_xfer || dma_xfer) && !hold_done)
        hold_cnt <= hold_cnt + HW'(1);
      if (state_nxt != state && state_nxt == ARB_CPU) rr_last <= SIDE_CPU;
      if (state_nxt != state && state_nxt == ARB_DMA) rr_last <= SIDE_DMA;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 uses round-robin, instance 1 CPU
// priority; both share the requester stimulus and each has its own memory.
module tb_mem_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;

  logic [1:0] cpu_gnt_w, dma_gnt_w, cpu_rvalid_w, dma_rvalid_w, mem_en_w, mem_we_w;
  logic [7:0] cpu_rdata_w [2];
  logic [7:0] dma_rdata_w [2];
  logic [7:0] mem_addr_w  [2];
  logic [7:0] mem_wdata_w [2];
  logic [7:0] mem_rdata_w [2];

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_HOLD(MAX_HOLD), .CPU_PRIORITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_w[0]), .cpu_rvalid(cpu_rvalid_w[0]), .cpu_rdata(cpu_rdata_w[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_w[0]), .dma_rvalid(dma_rvalid_w[0]), .dma_rdata(dma_rdata_w[0]),
    .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0])
  );

  mem_bus_arbiter #(.AW(8), .DW(8), .MAX_HOLD(MAX_HOLD), .CPU_PRIORITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_w[1]), .cpu_rvalid(cpu_rvalid_w[1]), .cpu_rdata(cpu_rdata_w[1]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_w[1]), .dma_rvalid(dma_rvalid_w[1]), .dma_rdata(dma_rdata_w[1]),
    .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1])
  );

  // Memories seen by the two instances: reads return one cycle later.
  logic [7:0] memArr [2][256];
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) memArr[k][i] = 8'(i) ^ 8'hA5;
      mem_rdata_w[k] = 8'h00;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (mem_en_w[k]) begin
          if (mem_we_w[k]) memArr[k][mem_addr_w[k]] = mem_wdata_w[k];
          else             mem_rdata_w[k] <= memArr[k][mem_addr_w[k]];
        end
      end
    end
  end

  // Reference model: owner (0 none, 1 CPU, 2 DMA), transfers made in the
  // current tenure, side granted most recently, pending read and its data.
  int         owner  [2];
  int         used   [2];
  int         last   [2];
  int         rdPend [2];
  logic [7:0] rdExp  [2];
  logic [7:0] refMem [2][256];

  function automatic bit reqOf(input int side);
    return (side == 1) ? cpu_req : (side == 2) ? dma_req : 1'b0;
  endfunction

  task automatic modelStep(input int k, input bit prio);
    int nxt;
    bit xr, xw;
    logic [7:0] xa, xd;
    if (!rst_n) begin
      owner[k] = 0; used[k] = 0; last[k] = 2; rdPend[k] = 0;
      return;
    end
    xr = (owner[k] != 0) && reqOf(owner[k]);
    xw = (owner[k] == 1) ? cpu_we    : dma_we;
    xa = (owner[k] == 1) ? cpu_addr  : dma_addr;
    xd = (owner[k] == 1) ? cpu_wdata : dma_wdata;
    rdPend[k] = (xr && !xw) ? owner[k] : 0;
    if (xr && !xw) rdExp[k] = refMem[k][xa];
    if (xr && xw)  refMem[k][xa] = xd;
    if (owner[k] == 0) begin
      if (cpu_req && dma_req) nxt = (prio || last[k] == 2) ? 1 : 2;
      else if (cpu_req)       nxt = 1;
      else if (dma_req)       nxt = 2;
      else                    nxt = 0;
    end else if (!reqOf(owner[k])) begin
      nxt = reqOf(3 - owner[k]) ? 3 - owner[k] : 0;
    end else begin
      used[k] = used[k] + 1;
      nxt = (reqOf(3 - owner[k]) && used[k] >= MAX_HOLD) ? 3 - owner[k] : owner[k];
    end
    if (nxt != owner[k]) begin
      used[k] = 0;
      if (nxt != 0) last[k] = nxt;
      owner[k] = nxt;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) refMem[k][i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge clk);
      modelStep(0, 1'b0);
      modelStep(1, 1'b1);
    end
  end

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d actual=%0h required=%0h", name, k, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checkOn) begin
        for (int k = 0; k < 2; k++) begin
          bit xr;
          xr = (owner[k] != 0) && reqOf(owner[k]);
          checkOutput("cmp_cpu_gnt", k, 32'(cpu_gnt_w[k]), 32'(owner[k] == 1));
          checkOutput("cmp_dma_gnt", k, 32'(dma_gnt_w[k]), 32'(owner[k] == 2));
          checkOutput("cmp_mem_en",  k, 32'(mem_en_w[k]),  32'(xr));
          checkOutput("cmp_mem_we",  k, 32'(mem_we_w[k]),
                      xr ? 32'((owner[k] == 1) ? cpu_we : dma_we) : 32'd0);
          checkOutput("cmp_mem_addr", k, 32'(mem_addr_w[k]),
                      xr ? 32'((owner[k] == 1) ? cpu_addr : dma_addr) : 32'd0);
          checkOutput("cmp_mem_wdata", k, 32'(mem_wdata_w[k]),
                      xr ? 32'((owner[k] == 1) ? cpu_wdata : dma_wdata) : 32'd0);
          checkOutput("cmp_cpu_rvalid", k, 32'(cpu_rvalid_w[k]), 32'(rdPend[k] == 1));
          checkOutput("cmp_dma_rvalid", k, 32'(dma_rvalid_w[k]), 32'(rdPend[k] == 2));
          if (rdPend[k] == 1) checkOutput("cmp_cpu_rdata", k, 32'(cpu_rdata_w[k]), 32'(rdExp[k]));
          if (rdPend[k] == 2) checkOutput("cmp_dma_rdata", k, 32'(dma_rdata_w[k]), 32'(rdExp[k]));
        end
      end
    end
  end

  task automatic applyStimulus(input logic rn,
                               input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                               input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    rst_n = rn;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  int cpuCnt0, dmaCnt0, busy0, cpuCnt1;

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 8'h00;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h20; dma_wdata = 8'h00;

    // Reset held two cycles with both requesting.
    @(posedge clk);
    #1 checkOn = 1'b1;
    @(negedge clk);
    checkOutput("rst_cpu_gnt", 0, 32'(cpu_gnt_w), 32'd0);
    checkOutput("rst_dma_gnt", 0, 32'(dma_gnt_w), 32'd0);
    checkOutput("rst_mem_en",  0, 32'(mem_en_w),  32'd0);
    applyStimulus(0, 1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    checkOutput("rst_rvalid", 0, 32'({cpu_rvalid_w, dma_rvalid_w}), 32'd0);
    applyStimulus(1, 1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
    applyStimulus(1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h20, 8'h00);
    @(negedge clk);
    checkOutput("first_gnt_cpu", 0, 32'(cpu_gnt_w), 32'h3);
    checkOutput("first_gnt_dma", 0, 32'(dma_gnt_w), 32'h0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    // Single CPU read of 0x10.
    applyStimulus(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd_gnt_latency", 0, 32'(cpu_gnt_w[0]), 32'd0);
    applyStimulus(1, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd_gnt",  0, 32'(cpu_gnt_w[0]), 32'd1);
    checkOutput("rd_addr", 0, 32'({mem_en_w[0], mem_addr_w[0]}), 32'h110);
    applyStimulus(1, 0, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rd_rvalid", 0, 32'(cpu_rvalid_w[0]), 32'd1);
    checkOutput("rd_rdata",  0, 32'(cpu_rdata_w[0]),  32'hB5);
    checkOutput("rd_dma_rvalid", 0, 32'(dma_rvalid_w), 32'd0);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    // Contention: CPU writes 0x40, DMA reads 0x40, both held.
    cpuCnt0 = 0; dmaCnt0 = 0; busy0 = 0; cpuCnt1 = 0;
    applyStimulus(1, 1, 1, 8'h40, 8'h00, 1, 0, 8'h40, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 1, 8'h40, 8'(i), 1, 0, 8'h40, 8'h00);
      @(negedge clk);
      if (i == 1) checkOutput("cont_first_rr",   0, 32'(dma_gnt_w[0]), 32'd1);
      if (i == 1) checkOutput("cont_first_prio", 1, 32'(cpu_gnt_w[1]), 32'd1);
      if (i == 5) checkOutput("cont_rvalid_handover", 0,
                              32'({dma_rvalid_w[0], cpu_gnt_w[0]}), 32'h3);
      cpuCnt0 += int'(cpu_gnt_w[0]);
      dmaCnt0 += int'(dma_gnt_w[0]);
      busy0   += int'(mem_en_w[0]);
      cpuCnt1 += int'(cpu_gnt_w[1]);
    end
    checkOutput("cont_cpu_cycles", 0, 32'(cpuCnt0), 32'd8);
    checkOutput("cont_dma_cycles", 0, 32'(dmaCnt0), 32'd8);
    checkOutput("cont_no_idle",    0, 32'(busy0),   32'd16);
    checkOutput("cont_cpu_cycles", 1, 32'(cpuCnt1), 32'd8);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);

    // Handover: DMA reads 0x30 twice, then drops as CPU raises its request.
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    @(negedge clk);
    checkOutput("ho_dma_gnt", 0, 32'(dma_gnt_w), 32'h3);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    applyStimulus(1, 1, 0, 8'h50, 8'h00, 0, 0, 8'h30, 8'h00);
    @(negedge clk);
    checkOutput("ho_dma_rvalid", 0, 32'(dma_rvalid_w[0]), 32'd1);
    checkOutput("ho_dma_rdata",  0, 32'(dma_rdata_w[0]),  32'h95);
    applyStimulus(1, 1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("ho_cpu_gnt", 0, 32'(cpu_gnt_w), 32'h3);

    // Reset asserted in the cycle of a CPU read transfer.
    applyStimulus(0, 1, 0, 8'h51, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rstmid_xfer", 0, 32'(mem_en_w[0]), 32'd1);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("rstmid_rvalid", 0, 32'(cpu_rvalid_w), 32'd0);
    checkOutput("rstmid_idle",   0, 32'({cpu_gnt_w, dma_gnt_w}), 32'd0);

    // One-cycle simultaneous pulses from IDLE.
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 1, 0, 8'h60, 8'h00, 1, 0, 8'h61, 8'h00);
      applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      checkOutput("pulse_rr",   0, 32'({cpu_gnt_w[0], dma_gnt_w[0]}),
                  (j % 2 == 0) ? 32'h2 : 32'h1);
      checkOutput("pulse_prio", 1, 32'({cpu_gnt_w[1], dma_gnt_w[1]}), 32'h2);
    end
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
